fir_axis_tx: RTL and testbench
==============================

FIR_AXIS_TX -- requirements
Module: fir_axis_tx

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the sample FIFO depth in entries (power of two).
REQ-002 Parameter GAP_CYCLES, default 2, SHALL set the number of idle cycles inserted after each frame.
REQ-003 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 wr_valid  input  1  SHALL indicate that wr_data holds a sample to enqueue.
REQ-006 wr_data  input  16  SHALL carry a signed Q1.15 sample.
REQ-007 wr_ready  output  1  SHALL indicate that the FIFO can accept a sample this cycle.
REQ-008 enable  input  1  SHALL permit new frames to start.
REQ-009 frame_len  input  8  SHALL give the samples per frame; value 0 SHALL be treated as 1.
REQ-010 m_axis_fir_tdata  output  16  SHALL carry the sample driven toward the FIR slave port.
REQ-011 m_axis_fir_tkeep  output  4  SHALL carry the byte-valid mask.
REQ-012 m_axis_fir_tlast  output  1  SHALL mark the final beat of a frame.
REQ-013 m_axis_fir_tvalid  output  1  SHALL indicate that the beat is valid.
REQ-014 m_axis_fir_tready  input  1  SHALL indicate that the downstream FIR accepts the beat.
REQ-015 fill_level  output  $clog2(DEPTH)+1  SHALL carry the current FIFO occupancy.
REQ-016 load_level  output  2  SHALL carry the quantised occupancy used by the DVS controller.
REQ-017 frames_sent  output  16  SHALL count completed frames.

Function
REQ-018 Enqueue SHALL occur when wr_valid && wr_ready; wr_ready SHALL equal (fill_level != DEPTH), with no credit for a same-cycle pop.
REQ-019 Dequeue SHALL occur only on the handshake m_axis_fir_tvalid && m_axis_fir_tready.
REQ-020 Simultaneous enqueue and dequeue SHALL leave fill_level unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-021 The FSM SHALL have exactly the states IDLE, SEND and GAP.
REQ-022 IDLE -> SEND SHALL occur when enable && fill_level != 0; on that transition frame_len SHALL be latched into len_q and beat_cnt SHALL be cleared to 0.
REQ-023 In SEND, m_axis_fir_tvalid SHALL be 1 whenever fill_level != 0, and 0 otherwise; outside SEND it SHALL be 0.
REQ-024 In SEND, m_axis_fir_tdata SHALL be the FIFO head entry.
REQ-025 Once m_axis_fir_tvalid rises, m_axis_fir_tvalid, tdata, tlast and tkeep SHALL hold stable until the handshake.
REQ-026 m_axis_fir_tkeep SHALL be 4'b0011 whenever m_axis_fir_tvalid=1, and 4'b0000 otherwise.
REQ-027 m_axis_fir_tlast SHALL be 1 when in SEND && beat_cnt == len_q-1 && m_axis_fir_tvalid=1.
REQ-028 Each handshake SHALL increment beat_cnt.
REQ-029 A handshake with tlast=1 SHALL move SEND -> GAP and SHALL increment frames_sent, wrapping 16'hFFFF -> 0.
REQ-030 GAP SHALL last exactly GAP_CYCLES cycles and then move to IDLE; GAP_CYCLES=0 SHALL go directly SEND -> IDLE.
REQ-031 Deasserting enable mid-frame SHALL NOT truncate the frame: the frame SHALL complete, and then no new frame SHALL start.
REQ-032 A FIFO underrun mid-frame SHALL drop tvalid and keep state SEND with beat_cnt preserved.
REQ-033 frame_len changes mid-frame SHALL have no effect until the next IDLE -> SEND transition.
REQ-034 Minimum latency from an enqueue into an empty FIFO (block in IDLE, enable=1) to m_axis_fir_tvalid SHALL be 2 cycles.
REQ-035 load_level SHALL be registered from fill_level: 00 for 0..DEPTH/4-1, 01 up to DEPTH/2-1, 10 up to 3*DEPTH/4-1, 11 otherwise.

Reset
REQ-036 Asserting reset SHALL immediately set state IDLE, pointers 0, fill_level 0, beat_cnt 0, frames_sent 0, load_level 00, tvalid/tlast 0, tkeep 0, tdata 0.
REQ-037 While reset=1, wr_ready SHALL be 0; after release it SHALL be 1.
REQ-038 Reset mid-frame SHALL discard all FIFO contents and the partial frame, with no tlast emitted.

Verification
REQ-039 Scenario: frame_len=4, GAP_CYCLES=2, write 1,2,3,4 with tready=1 -> four beats 1,2,3,4; tlast only on beat 4; frames_sent=1; tvalid=0 for 2 cycles; then IDLE.
REQ-040 Scenario: write 16 samples with tready=0 -> wr_ready=0, fill_level=16, load_level=11; a 17th write is refused; tdata holds sample 1 stable throughout.
REQ-041 Scenario: frame_len=3, write 1 sample, then 2 more 5 cycles later -> tvalid drops between them; tlast on the 3rd beat only.
REQ-042 Scenario: frame_len=0, write 2 samples, GAP_CYCLES=2 -> two frames of 1 beat, each with tlast=1, separated by 2 idle cycles, plus 1 cycle for the IDLE -> SEND transition; frames_sent=2.
REQ-043 Scenario: enable drops after beat 2 of a frame_len=4 frame -> beats 3 and 4 are still sent; no further tvalid while enable=0.
REQ-044 Scenario: reset asserted at beat 2 of 4 -> all outputs 0 in the same cycle; after release, fill_level=0 and frames_sent=0.

Source files
------------

// File: rtl/fir_axis_tx_if.sv
// AXI-Stream beat bus between the sample transmitter and the FIR slave port.
// The master drives the beat fields; the slave returns tready.
interface fir_axis_tx_if;
    logic [15:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/fir_axis_tx.sv
// Sample FIFO feeding framed AXI-Stream beats toward the FIR, with an idle gap
// after each frame, an occupancy level for the DVS controller and a frame counter.
//
// state | meaning
// IDLE  | waiting for enable and a non-empty FIFO; latches frame length
// SEND  | streaming FIFO head; tvalid follows FIFO non-empty
// GAP   | GAP_CYCLES idle cycles after a frame's last beat
module fir_axis_tx #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid_i,
    input  logic [15:0]             wr_data_i,
    output logic                    wr_ready_o,
    input  logic                    enable_i,
    input  logic [7:0]              frame_len_i,
    fir_axis_tx_if.master           m_axis_fir,
    output logic [$clog2(DEPTH):0]  fill_level_o,
    output logic [1:0]              load_level_o,
    output logic [15:0]             frames_sent_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] Q1   = (AW+1)'(DEPTH / 4);
    localparam logic [AW:0] Q2   = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0] Q3   = (AW+1)'((3 * DEPTH) / 4);
    localparam int          GAP_M1   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [15:0] GAP_LOAD = 16'(GAP_M1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fill_q;
    logic [1:0]    load_q, load_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    beat_q, beat_d;
    logic [15:0]   gap_q, gap_d;
    logic [15:0]   frames_q, frames_d;
    logic          push, pop, tvalid, tlast;

    // wr_ready takes no credit for a same-cycle pop, and is low during reset
    assign wr_ready_o = !reset && (fill_q != FULL);
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = tvalid && m_axis_fir.tready;

    assign tvalid = (state_q == SEND) && (fill_q != '0);
    assign tlast  = tvalid && (beat_q == len_q - 8'd1);

    assign m_axis_fir.tvalid = tvalid;
    assign m_axis_fir.tlast  = tlast;
    assign m_axis_fir.tkeep  = tvalid ? 4'b0011 : 4'b0000;
    assign m_axis_fir.tdata  = tvalid ? mem_q[rd_ptr_q] : 16'h0000;

    assign fill_level_o  = fill_q;
    assign load_level_o  = load_q;
    assign frames_sent_o = frames_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_comb begin
        if (fill_q < Q1)      load_d = 2'b00;
        else if (fill_q < Q2) load_d = 2'b01;
        else if (fill_q < Q3) load_d = 2'b10;
        else                  load_d = 2'b11;
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        frames_d = frames_q;
        case (state_q)
            IDLE: begin
                if (enable_i && (fill_q != '0)) begin
                    state_d = SEND;
                    len_d   = (frame_len_i == 8'd0) ? 8'd1 : frame_len_i;
                    beat_d  = 8'd0;
                end
            end
            SEND: begin
                if (pop) begin
                    beat_d = beat_q + 8'd1;
                    if (tlast) begin
                        frames_d = frames_q + 16'd1;
                        if (GAP_CYCLES == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == 16'd0) state_d = IDLE;
                else                gap_d   = gap_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= 8'd1;
            beat_q   <= 8'd0;
            gap_q    <= 16'd0;
            frames_q <= 16'd0;
            load_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            frames_q <= frames_d;
            load_q   <= load_d;
        end
    end
endmodule

// File: tb/tb_fir_axis_tx.sv
// Directed bench for fir_axis_tx: framing, gaps, back-pressure, underrun,
// enable drop and mid-frame reset, with expected values written out by hand.
module tb_fir_axis_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        enable;
    logic [7:0]  frame_len;
    logic [4:0]  fill_level;
    logic [1:0]  load_level;
    logic [15:0] frames_sent;

    fir_axis_tx_if axis ();

    fir_axis_tx #(.DEPTH(16), .GAP_CYCLES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid_i    (wr_valid),
        .wr_data_i     (wr_data),
        .wr_ready_o    (wr_ready),
        .enable_i      (enable),
        .frame_len_i   (frame_len),
        .m_axis_fir    (axis),
        .fill_level_o  (fill_level),
        .load_level_o  (load_level),
        .frames_sent_o (frames_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // beat monitor: handshakes, cycle stamps, stability and tkeep rules
    logic [15:0] beat_data [$];
    logic        beat_last [$];
    int          beat_cyc  [$];
    int          cyc       = 0;
    int          stab_err  = 0;
    int          keep_err  = 0;
    int          valid_cnt = 0;
    logic        pend      = 1'b0;
    logic [15:0] pend_data = 16'h0;
    logic        pend_last = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend && (!axis.tvalid || axis.tdata !== pend_data || axis.tlast !== pend_last))
                stab_err++;
            if (axis.tvalid ? (axis.tkeep !== 4'b0011) : (axis.tkeep !== 4'b0000))
                keep_err++;
            if (axis.tvalid) valid_cnt++;
            if (axis.tvalid && axis.tready) begin
                beat_data.push_back(axis.tdata);
                beat_last.push_back(axis.tlast);
                beat_cyc.push_back(cyc);
            end
            pend      = axis.tvalid && !axis.tready;
            pend_data = axis.tdata;
            pend_last = axis.tlast;
        end
    end

    task automatic clear_mon();
        @(negedge clk);
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        valid_cnt = 0;
    endtask

    task automatic push_one(input logic [15:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (!wr_ready && t < 50) begin
            wr_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (!wr_ready) check_eq("push_timeout", 32'(wr_ready), 1);
        wr_valid = 1'b1;
        wr_data  = d;
    endtask

    task automatic push_stop();
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t;
        t = 0;
        while (beat_data.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (beat_data.size() < n) check_eq("beat_timeout", 32'(beat_data.size()), 32'(n));
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [15:0] d, input logic l);
        if (idx < beat_data.size()) begin
            check_eq($sformatf("%s[%0d].data", tag, idx), 32'(beat_data[idx]), 32'(d));
            check_eq($sformatf("%s[%0d].last", tag, idx), 32'(beat_last[idx]), 32'(l));
        end else begin
            check_eq($sformatf("%s[%0d].missing", tag, idx), 32'(beat_data.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_data = 16'h0;
        enable = 1'b0; frame_len = 8'd4; axis.tready = 1'b0;

        // reset state
        #2;
        check_eq("rst.wr_ready", 32'(wr_ready), 0);
        check_eq("rst.fill",     32'(fill_level), 0);
        check_eq("rst.load",     32'(load_level), 0);
        check_eq("rst.frames",   32'(frames_sent), 0);
        check_eq("rst.tvalid",   32'(axis.tvalid), 0);
        check_eq("rst.tkeep",    32'(axis.tkeep), 0);
        check_eq("rst.tdata",    32'(axis.tdata), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rel.wr_ready", 32'(wr_ready), 1);

        // basic frame of 4, tready=1
        enable = 1'b1; frame_len = 8'd4; axis.tready = 1'b1;
        clear_mon();
        for (int i = 1; i <= 4; i++) push_one(16'(i));
        push_stop();
        wait_beats(4, 30);
        wait_cyc(4);
        for (int i = 0; i < 4; i++) check_beat("s1", i, 16'(i + 1), i == 3);
        if (beat_cyc.size() == 4) check_eq("s1.back_to_back", 32'(beat_cyc[3] - beat_cyc[0]), 3);
        check_eq("s1.frames", 32'(frames_sent), 1);
        check_eq("s1.fill",   32'(fill_level), 0);
        check_eq("s1.tvalid", 32'(axis.tvalid), 0);

        // fill to full under back-pressure, then drain
        axis.tready = 1'b0;
        clear_mon();
        for (int i = 1; i <= 3; i++) push_one(16'h0100 + 16'(i));
        push_stop(); wait_cyc(2);
        check_eq("s2.fill3", 32'(fill_level), 3);
        check_eq("s2.load3", 32'(load_level), 0);
        for (int i = 4; i <= 7; i++) push_one(16'h0100 + 16'(i));
        push_stop(); wait_cyc(2);
        check_eq("s2.load7", 32'(load_level), 1);
        for (int i = 8; i <= 11; i++) push_one(16'h0100 + 16'(i));
        push_stop(); wait_cyc(2);
        check_eq("s2.load11", 32'(load_level), 2);
        for (int i = 12; i <= 16; i++) push_one(16'h0100 + 16'(i));
        push_stop(); wait_cyc(2);
        check_eq("s2.fill16",   32'(fill_level), 16);
        check_eq("s2.load16",   32'(load_level), 3);
        check_eq("s2.wr_ready", 32'(wr_ready), 0);
        wr_valid = 1'b1; wr_data = 16'h7777;
        @(negedge clk);
        wr_valid = 1'b0;
        check_eq("s2.refused_fill", 32'(fill_level), 16);
        check_eq("s2.head_data",    32'(axis.tdata), 32'h0101);
        check_eq("s2.head_valid",   32'(axis.tvalid), 1);
        check_eq("s2.no_beats",     32'(beat_data.size()), 0);
        axis.tready = 1'b1;
        wait_beats(16, 100);
        wait_cyc(5);
        for (int i = 0; i < 16; i++) check_beat("s2", i, 16'h0101 + 16'(i), (i % 4) == 3);
        check_eq("s2.frames", 32'(frames_sent), 5);
        check_eq("s2.fill",   32'(fill_level), 0);

        // underrun mid-frame, frame_len change mid-frame ignored
        frame_len = 8'd3;
        clear_mon();
        push_one(16'h8000);
        push_stop();
        wait_beats(1, 20);
        frame_len = 8'd5;
        wait_cyc(5);
        check_eq("s3.underrun_tvalid", 32'(axis.tvalid), 0);
        push_one(16'hFFFF);
        push_one(16'h7FFF);
        push_stop();
        wait_beats(3, 20);
        wait_cyc(4);
        check_beat("s3", 0, 16'h8000, 1'b0);
        check_beat("s3", 1, 16'hFFFF, 1'b0);
        check_beat("s3", 2, 16'h7FFF, 1'b1);
        if (beat_cyc.size() >= 2) check_eq("s3.stall", 32'(beat_cyc[1] - beat_cyc[0] > 1), 1);
        check_eq("s3.frames", 32'(frames_sent), 6);

        // frame_len=0 -> single-beat frames, gap of 2 plus IDLE cycle
        frame_len = 8'd0;
        clear_mon();
        push_one(16'h1111);
        push_one(16'h2222);
        push_stop();
        wait_beats(2, 30);
        wait_cyc(4);
        check_beat("s4", 0, 16'h1111, 1'b1);
        check_beat("s4", 1, 16'h2222, 1'b1);
        if (beat_cyc.size() == 2) check_eq("s4.spacing", 32'(beat_cyc[1] - beat_cyc[0]), 4);
        check_eq("s4.valid_cycles", 32'(valid_cnt), 2);
        check_eq("s4.frames", 32'(frames_sent), 8);

        // enable drops after beat 2: frame completes, nothing new starts
        enable = 1'b0; frame_len = 8'd4;
        clear_mon();
        for (int i = 1; i <= 6; i++) push_one(16'h0A00 + 16'(i));
        push_stop();
        wait_cyc(2);
        check_eq("s5.idle_tvalid", 32'(axis.tvalid), 0);
        check_eq("s5.idle_fill",   32'(fill_level), 6);
        enable = 1'b1;
        wait_beats(2, 20);
        enable = 1'b0;
        wait_beats(4, 20);
        wait_cyc(8);
        check_eq("s5.beats", 32'(beat_data.size()), 4);
        for (int i = 0; i < 4; i++) check_beat("s5", i, 16'h0A01 + 16'(i), i == 3);
        check_eq("s5.valid_cycles", 32'(valid_cnt), 4);
        check_eq("s5.fill",   32'(fill_level), 2);
        check_eq("s5.frames", 32'(frames_sent), 9);
        frame_len = 8'd2;
        enable = 1'b1;
        wait_beats(6, 20);
        wait_cyc(4);
        check_beat("s5", 4, 16'h0A05, 1'b0);
        check_beat("s5", 5, 16'h0A06, 1'b1);
        check_eq("s5.frames2", 32'(frames_sent), 10);

        // reset at beat 2 of 4
        enable = 1'b0; frame_len = 8'd4;
        clear_mon();
        for (int i = 1; i <= 4; i++) push_one(16'h0B00 + 16'(i));
        push_stop();
        enable = 1'b1;
        wait_beats(2, 20);
        reset = 1'b1;
        #1;
        check_eq("s6.tvalid",   32'(axis.tvalid), 0);
        check_eq("s6.tlast",    32'(axis.tlast), 0);
        check_eq("s6.tkeep",    32'(axis.tkeep), 0);
        check_eq("s6.tdata",    32'(axis.tdata), 0);
        check_eq("s6.fill",     32'(fill_level), 0);
        check_eq("s6.frames",   32'(frames_sent), 0);
        check_eq("s6.wr_ready", 32'(wr_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("s6.rel_wr_ready", 32'(wr_ready), 1);
        wait_cyc(6);
        check_eq("s6.beats",    32'(beat_data.size()), 2);
        check_beat("s6", 0, 16'h0B01, 1'b0);
        check_beat("s6", 1, 16'h0B02, 1'b0);
        check_eq("s6.post_fill",   32'(fill_level), 0);
        check_eq("s6.post_frames", 32'(frames_sent), 0);
        check_eq("s6.post_tvalid", 32'(axis.tvalid), 0);

        check_eq("stability_violations", 32'(stab_err), 0);
        check_eq("tkeep_violations",     32'(keep_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
